// File: rtl/sm_ctrl_if.sv
// Bus between the instruction source and the sm_ctrl controller.
// The master issues instructions (s, in) and watches w; the slave is the
// controller, which drives every datapath strobe and select.
interface sm_ctrl_if;
    logic        s;
    logic [15:0] in;
    logic        w;
    logic [3:0]  vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output s, in,
        input  w, vsel, readnum, writenum, write, loada, loadb, loadc,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  s, in,
        output w, vsel, readnum, writenum, write, loada, loadb, loadc,
               asel, bsel, shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/sm_ctrl.sv
// sm_ctrl: Moore controller for a small register/ALU datapath.
// Latches an instruction word into IR when idle, decodes it, and steps the
// datapath through load-A / load-B / ALU / write-back phases.
module sm_ctrl (
    input  logic     clk,
    input  logic     reset_n,
    sm_ctrl_if.slave bus
);

    localparam logic [2:0] ST_WAIT      = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_WRITE_IMM = 3'd2;
    localparam logic [2:0] ST_GET_A     = 3'd3;
    localparam logic [2:0] ST_GET_B     = 3'd4;
    localparam logic [2:0] ST_ALU       = 3'd5;
    localparam logic [2:0] ST_WRITE_REG = 3'd6;

    logic [15:0] ir;
    logic [2:0]  state;
    logic [2:0]  next_state;

    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;

    logic        accept;
    logic        is_alu;
    logic        is_mov_imm;
    logic        is_mov_reg;
    logic        is_cmp;
    logic        is_mvn;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_alu     = (opcode == 3'b101);
    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // A start strobe only counts while the controller is idle.
    assign accept = (state == ST_WAIT) && bus.s;

    assign bus.sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign bus.sximm5 = {{11{ir[4]}}, ir[4:0]};

    // Instruction register: captures the word on an accepted start, else holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir <= 16'h0000;
        end else if (accept) begin
            ir <= bus.in;
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: dispatch in DECODE, fixed sequences elsewhere.
    always_comb begin
        next_state = ST_WAIT;
        case (state)
            ST_WAIT:      next_state = bus.s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm) begin
                    next_state = ST_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = ST_GET_B;
                end else if (is_alu) begin
                    next_state = ST_GET_A;
                end else begin
                    next_state = ST_WAIT;
                end
            end
            ST_WRITE_IMM: next_state = ST_WAIT;
            ST_GET_A:     next_state = ST_GET_B;
            ST_GET_B:     next_state = ST_ALU;
            ST_ALU:       next_state = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: next_state = ST_WAIT;
            default:      next_state = ST_WAIT;
        endcase
    end

    // Moore outputs: everything idles at zero, each state raises only its own controls.
    always_comb begin
        bus.w        = 1'b0;
        bus.vsel     = 4'b0000;
        bus.readnum  = 3'b000;
        bus.writenum = 3'b000;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;
        case (state)
            ST_WAIT: begin
                bus.w = 1'b1;
            end
            ST_WRITE_IMM: begin
                bus.write    = 1'b1;
                bus.vsel     = 4'b0100;
                bus.writenum = rn;
            end
            ST_GET_A: begin
                bus.loada   = 1'b1;
                bus.readnum = rn;
            end
            ST_GET_B: begin
                bus.loadb   = 1'b1;
                bus.readnum = rm;
            end
            ST_ALU: begin
                bus.loadc = 1'b1;
                bus.shift = sh;
                bus.asel  = is_mov_reg || is_mvn;
                bus.ALUop = is_alu ? op : 2'b00;
            end
            ST_WRITE_REG: begin
                bus.write    = 1'b1;
                bus.vsel     = 4'b0001;
                bus.writenum = rd;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sm_ctrl.sv
// Directed testbench for sm_ctrl: a table of per-cycle vectors covering each
// instruction class, plus hand-written reset sequences.
module tb_sm_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    sm_ctrl_if bus ();

    sm_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        w;
        logic [3:0]  vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } outs_t;

    typedef struct {
        string       name;
        logic        s;
        logic [15:0] in;
        outs_t       exp;
    } vec_t;

    // Strobe groups in {write, loada, loadb, loadc, asel, bsel} order.
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] WR   = 6'b100000;
    localparam logic [5:0] LA   = 6'b010000;
    localparam logic [5:0] LB   = 6'b001000;
    localparam logic [5:0] LC   = 6'b000100;
    localparam logic [5:0] LC_A = 6'b000110;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic outs_t mk(logic w, logic [3:0] vsel, logic [2:0] rn, logic [2:0] wn,
                                 logic [5:0] stb, logic [1:0] sh, logic [1:0] aop,
                                 logic [15:0] sx8, logic [15:0] sx5);
        outs_t o;
        o.w        = w;
        o.vsel     = vsel;
        o.readnum  = rn;
        o.writenum = wn;
        o.write    = stb[5];
        o.loada    = stb[4];
        o.loadb    = stb[3];
        o.loadc    = stb[2];
        o.asel     = stb[1];
        o.bsel     = stb[0];
        o.shift    = sh;
        o.alu_op   = aop;
        o.sximm8   = sx8;
        o.sximm5   = sx5;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.w        = bus.w;
        o.vsel     = bus.vsel;
        o.readnum  = bus.readnum;
        o.writenum = bus.writenum;
        o.write    = bus.write;
        o.loada    = bus.loada;
        o.loadb    = bus.loadb;
        o.loadc    = bus.loadc;
        o.asel     = bus.asel;
        o.bsel     = bus.bsel;
        o.shift    = bus.shift;
        o.alu_op   = bus.ALUop;
        o.sximm8   = bus.sximm8;
        o.sximm5   = bus.sximm5;
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("w=%b vsel=%b rd=%0d wn=%0d wr/la/lb/lc/as/bs=%b%b%b%b%b%b sh=%b aluop=%b sx8=%h sx5=%h",
                         o.w, o.vsel, o.readnum, o.writenum, o.write, o.loada, o.loadb,
                         o.loadc, o.asel, o.bsel, o.shift, o.alu_op, o.sximm8, o.sximm5);
    endfunction

    task automatic addVec(string name, logic s, logic [15:0] in, outs_t exp);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.in   = in;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    // Drive inputs, let one rising edge pass, then settle just after it.
    task automatic applyStimulus(logic s, logic [15:0] in);
        bus.s  = s;
        bus.in = in;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, outs_t exp);
        outs_t act;
        int    hot;
        act = sample();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
        end
        hot = int'(act.write) + int'(act.loada) + int'(act.loadb) + int'(act.loadc);
        compared++;
        if (hot > 1) begin
            mismatched++;
            $display("[TB] FAIL %s_onehot: got %0d load/write strobes high, want at most 1", name, hot);
        end
    endtask

    initial begin
        // MOV R1,#5
        addVec("movi_decode", 1'b1, 16'hD105, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("movi_write",  1'b0, 16'h0000, mk(1'b0, 4'b0100, 3'd0, 3'd1, WR,   2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("movi_done",   1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("idle_hold",   1'b0, 16'hFFFF, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        // ADD R5,R0,R2 LSL1 with a busy start strobe carrying D2FF throughout
        addVec("add_decode",  1'b1, 16'hA0AA, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFAA, 16'h000A));
        addVec("add_geta",    1'b1, 16'hD2FF, mk(1'b0, 4'b0000, 3'd0, 3'd0, LA,   2'b00, 2'b00, 16'hFFAA, 16'h000A));
        addVec("add_getb",    1'b1, 16'hD2FF, mk(1'b0, 4'b0000, 3'd2, 3'd0, LB,   2'b00, 2'b00, 16'hFFAA, 16'h000A));
        addVec("add_alu",     1'b1, 16'hD2FF, mk(1'b0, 4'b0000, 3'd0, 3'd0, LC,   2'b01, 2'b00, 16'hFFAA, 16'h000A));
        addVec("add_wreg",    1'b1, 16'hD2FF, mk(1'b0, 4'b0001, 3'd0, 3'd5, WR,   2'b00, 2'b00, 16'hFFAA, 16'h000A));
        addVec("add_done",    1'b1, 16'hD2FF, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFAA, 16'h000A));
        // CMP R1,R0
        addVec("cmp_decode",  1'b1, 16'hA900, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("cmp_geta",    1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd1, 3'd0, LA,   2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("cmp_getb",    1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd0, 3'd0, LB,   2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("cmp_alu",     1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd0, 3'd0, LC,   2'b00, 2'b01, 16'h0000, 16'h0000));
        addVec("cmp_done",    1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        // Undefined encodings
        addVec("undef_decode",  1'b1, 16'hE000, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("undef_done",    1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("undef2_decode", 1'b1, 16'hC800, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        addVec("undef2_done",   1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        // MOV R3,R4 LSR
        addVec("movr_decode", 1'b1, 16'hC074, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0074, 16'hFFF4));
        addVec("movr_getb",   1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd4, 3'd0, LB,   2'b00, 2'b00, 16'h0074, 16'hFFF4));
        addVec("movr_alu",    1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd0, 3'd0, LC_A, 2'b10, 2'b00, 16'h0074, 16'hFFF4));
        addVec("movr_wreg",   1'b0, 16'h0000, mk(1'b0, 4'b0001, 3'd0, 3'd3, WR,   2'b00, 2'b00, 16'h0074, 16'hFFF4));
        addVec("movr_done",   1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0074, 16'hFFF4));
        // MVN R7,R1
        addVec("mvn_decode",  1'b1, 16'hB8E1, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFE1, 16'h0001));
        addVec("mvn_getb",    1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd1, 3'd0, LB,   2'b00, 2'b00, 16'hFFE1, 16'h0001));
        addVec("mvn_alu",     1'b0, 16'h0000, mk(1'b0, 4'b0000, 3'd0, 3'd0, LC_A, 2'b00, 2'b11, 16'hFFE1, 16'h0001));
        addVec("mvn_wreg",    1'b0, 16'h0000, mk(1'b0, 4'b0001, 3'd0, 3'd7, WR,   2'b00, 2'b00, 16'hFFE1, 16'h0001));
        addVec("mvn_done",    1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFE1, 16'h0001));
        // s held high: MOV R1,#5 then MOV R3,#-1 back to back
        addVec("b2b_decode1", 1'b1, 16'hD105, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("b2b_write1",  1'b1, 16'hD3FF, mk(1'b0, 4'b0100, 3'd0, 3'd1, WR,   2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("b2b_wait",    1'b1, 16'hD3FF, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        addVec("b2b_decode2", 1'b1, 16'hD3FF, mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFFF, 16'hFFFF));
        addVec("b2b_write2",  1'b0, 16'h0000, mk(1'b0, 4'b0100, 3'd0, 3'd3, WR,   2'b00, 2'b00, 16'hFFFF, 16'hFFFF));
        addVec("b2b_done",    1'b0, 16'h0000, mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'hFFFF, 16'hFFFF));

        // Power-on reset, released between clock edges
        reset_n = 1'b0;
        bus.s   = 1'b0;
        bus.in  = 16'h0000;
        #12;
        checkOutput("reset_state", mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s, vecs[i].in);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Reset during GET_B of an ADD aborts it asynchronously
        applyStimulus(1'b1, 16'hA0AA);
        applyStimulus(1'b0, 16'h0000);
        applyStimulus(1'b0, 16'h0000);
        checkOutput("rst_pre_getb", mk(1'b0, 4'b0000, 3'd2, 3'd0, LB, 2'b00, 2'b00, 16'hFFAA, 16'h000A));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_async", mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));

        // Start strobes during reset are ignored
        applyStimulus(1'b1, 16'hD105);
        checkOutput("rst_held1", mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        applyStimulus(1'b1, 16'hD105);
        checkOutput("rst_held2", mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));

        // After release the aborted ADD never resumes and nothing starts without s
        bus.s = 1'b0;
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'hA0AA);
            checkOutput($sformatf("rst_after%0d", i),
                        mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0000, 16'h0000));
        end

        // A fresh start after reset runs normally
        applyStimulus(1'b1, 16'hD105);
        checkOutput("fresh_decode", mk(1'b0, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));
        applyStimulus(1'b0, 16'h0000);
        checkOutput("fresh_write", mk(1'b0, 4'b0100, 3'd0, 3'd1, WR, 2'b00, 2'b00, 16'h0005, 16'h0005));
        applyStimulus(1'b0, 16'h0000);
        checkOutput("fresh_done", mk(1'b1, 4'b0000, 3'd0, 3'd0, NONE, 2'b00, 2'b00, 16'h0005, 16'h0005));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
